// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control sequencer: state codes, opcode header
// classes and the memory sub-select.
package control_pkg;

  typedef enum logic [3:0] {
    ST_IF      = 4'd0,
    ST_RF      = 4'd1,
    ST_IMM3    = 4'd2,
    ST_ALU_R3  = 4'd3,
    ST_ALU_RI3 = 4'd4,
    ST_ALU4    = 4'd5,
    ST_BR3     = 4'd6,
    ST_MEM3    = 4'd7,
    ST_LD4     = 4'd8,
    ST_ST4     = 4'd9,
    ST_LD5     = 4'd10,
    ST_JMP3    = 4'd11,
    ST_HALT    = 4'd12
  } state_e;

  localparam logic [1:0] HDR_ALU_R    = 2'b00;
  localparam logic [1:0] HDR_ALU_RI   = 2'b01;
  localparam logic [2:0] HDR_BRANCH   = 3'b100;
  localparam logic [2:0] HDR_MEMREF   = 3'b101;
  localparam logic [2:0] HDR_JUMP     = 3'b110;
  localparam logic [2:0] HDR_LDI_HALT = 3'b111;

  localparam logic MEM_SEL_LD  = 1'b0;
  localparam logic MEM_SEL_STR = 1'b1;

  // States that hold the memory request while waiting for completion.
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_IF) || (s == ST_LD4) || (s == ST_ST4);
  endfunction

endpackage

// File: rtl/control_perf_counters.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module control_perf_counters #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             retire_i,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] retire_count_o
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  // Next-count computation.
  always_comb begin
    cycle_d  = cycle_q + 1'b1;
    retire_d = retire_q;
    if (retire_i) begin
      retire_d = retire_q + 1'b1;
    end else begin
      retire_d = retire_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
    end
  end

  assign cycle_count_o  = cycle_q;
  assign retire_count_o = retire_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: fetch, register fetch and class-specific execute,
// memory and writeback states, with memory wait, global stall, HALT and perf counters.
module multicycle_control_fsm
  import control_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int CNT_W       = 16,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                stall_i,
  input  logic                mem_ready_i,
  output logic [3:0]          state_o,
  output logic                mem_req_o,
  output logic                instr_done_o,
  output logic                halted_o,
  output logic [CNT_W-1:0]    cycle_count_o,
  output logic [CNT_W-1:0]    retire_count_o
);

  state_e     state_q, state_d;
  logic       instr_done_q, instr_done_d;
  logic       retire_s;
  logic       ready_s;
  logic [2:0] hdr_s;
  logic       mem_sel_s;

  assign hdr_s     = opcode_i[OPCODE_W-1 -: 3];
  assign mem_sel_s = opcode_i[OPCODE_W-4];
  assign ready_s   = MEM_WAIT_EN ? mem_ready_i : 1'b1;

  // Next-state decode and retirement detection.
  always_comb begin
    state_d      = state_q;
    instr_done_d = instr_done_q;
    retire_s     = 1'b0;
    if (stall_i) begin
      state_d      = state_q;
      instr_done_d = instr_done_q;
    end else begin
      instr_done_d = 1'b0;
      case (state_q)
        ST_IF: begin
          if (ready_s) state_d = ST_RF;
          else         state_d = ST_IF;
        end
        ST_RF: begin
          if (hdr_s[2:1] == HDR_ALU_R)       state_d = ST_ALU_R3;
          else if (hdr_s[2:1] == HDR_ALU_RI) state_d = ST_ALU_RI3;
          else if (hdr_s == HDR_BRANCH)      state_d = ST_BR3;
          else if (hdr_s == HDR_MEMREF)      state_d = ST_MEM3;
          else if (hdr_s == HDR_JUMP)        state_d = ST_JMP3;
          else if (&opcode_i)                state_d = ST_HALT;
          else                               state_d = ST_IMM3;
        end
        ST_ALU_R3, ST_ALU_RI3: state_d = ST_ALU4;
        ST_MEM3: begin
          if (mem_sel_s == MEM_SEL_LD) state_d = ST_LD4;
          else                         state_d = ST_ST4;
        end
        ST_LD4: begin
          if (ready_s) state_d = ST_LD5;
          else         state_d = ST_LD4;
        end
        ST_ST4: begin
          if (ready_s) begin
            state_d      = ST_IF;
            instr_done_d = 1'b1;
          end else begin
            state_d      = ST_ST4;
          end
        end
        ST_IMM3, ST_ALU4, ST_BR3, ST_LD5, ST_JMP3: begin
          state_d      = ST_IF;
          instr_done_d = 1'b1;
        end
        ST_HALT: state_d = ST_HALT;
        // Codes 13-15 recover to fetch without retiring anything.
        default: state_d = ST_IF;
      endcase
      retire_s = instr_done_d;
    end
  end

  // State and retirement-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IF;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= instr_done_d;
    end
  end

  assign state_o      = state_q;
  assign instr_done_o = instr_done_q;
  assign mem_req_o    = is_mem_state(state_q);
  assign halted_o     = (state_q == ST_HALT);

  control_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .retire_i      (retire_s),
    .cycle_count_o (cycle_count_o),
    .retire_count_o(retire_count_o)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: directed scenarios plus random opcode/stall/mem_ready traffic,
// checked every cycle against a path-based reference of each instruction class.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        stall;
  logic        mem_ready;

  logic [3:0]  state, state4;
  logic        mem_req, mem_req4, done, done4, halted, halted4;
  logic [15:0] cyc, ret;
  logic [3:0]  cyc4, ret4;

  int total = 0;
  int bad   = 0;

  int          m_state;
  int          m_path[$];
  bit          m_done;
  int unsigned m_cyc, m_ret;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.OPCODE_W(6), .CNT_W(16), .MEM_WAIT_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .stall_i(stall), .mem_ready_i(mem_ready),
    .state_o(state), .mem_req_o(mem_req), .instr_done_o(done), .halted_o(halted),
    .cycle_count_o(cyc), .retire_count_o(ret));

  multicycle_control_fsm #(.OPCODE_W(6), .CNT_W(4), .MEM_WAIT_EN(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .stall_i(stall), .mem_ready_i(mem_ready),
    .state_o(state4), .mem_req_o(mem_req4), .instr_done_o(done4), .halted_o(halted4),
    .cycle_count_o(cyc4), .retire_count_o(ret4));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_path.delete();
    m_done  = 1'b0;
    m_cyc   = 0;
    m_ret   = 0;
  endtask

  // Remaining states of an instruction after register fetch, by opcode class.
  task automatic build_path(input logic [5:0] op);
    m_path.delete();
    if (op == 6'h3F)              m_path = '{12};
    else if (op[5:4] == 2'b00)    m_path = '{3, 5};
    else if (op[5:4] == 2'b01)    m_path = '{4, 5};
    else if (op[5:3] == 3'b100)   m_path = '{6};
    else if (op[5:3] == 3'b101)   m_path = op[2] ? '{7, 9} : '{7, 8, 10};
    else if (op[5:3] == 3'b110)   m_path = '{11};
    else                          m_path = '{2};
  endtask

  task automatic model_edge();
    m_cyc++;
    if (stall) return;
    m_done = 1'b0;
    if ((m_state == 0 || m_state == 8 || m_state == 9) && !mem_ready) return;
    if (m_state == 0) m_state = 1;
    else if (m_state == 1) begin
      build_path(opcode);
      m_state = m_path.pop_front();
    end else if (m_state == 12) m_state = 12;
    else if (m_path.size() > 0) m_state = m_path.pop_front();
    else begin
      m_state = 0;
      m_done  = 1'b1;
      m_ret++;
    end
  endtask

  task automatic check_all();
    logic exp_req;
    exp_req = (m_state == 0) || (m_state == 8) || (m_state == 9);
    check_eq("state",   state,   m_state);
    check_eq("done",    done,    m_done);
    check_eq("mem_req", mem_req, exp_req);
    check_eq("halted",  halted,  m_state == 12);
    check_eq("cyc",     cyc,     m_cyc & 32'hFFFF);
    check_eq("ret",     ret,     m_ret & 32'hFFFF);
    check_eq("state4",  state4,  m_state);
    check_eq("done4",   done4,   m_done);
    check_eq("cyc4",    cyc4,    m_cyc & 32'hF);
    check_eq("ret4",    ret4,    m_ret & 32'hF);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Called 1 time unit after a rising edge; checks take effect before the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_state", state, 0);
    check_eq("rst_done",  done,  0);
    check_eq("rst_cyc",   cyc,   0);
    check_eq("rst_ret",   ret,   0);
    check_eq("rst_halt",  halted, 0);
    check_eq("rst_ret4",  ret4,  0);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'd0; stall = 1'b0; mem_ready = 1'b1;
    #22;
    check_eq("init_state", state, 0);
    check_eq("init_cyc",   cyc,   0);
    check_eq("init_done",  done,  0);
    model_reset();
    rst_n = 1'b1;

    // ALU-register instruction: 0,1,3,5,0
    cycle(); check_eq("t1_s1", state, 1);
    cycle(); check_eq("t1_s2", state, 3);
    cycle(); check_eq("t1_s3", state, 5);
    cycle(); check_eq("t1_s4", state, 0);
    check_eq("t1_done", done, 1);
    check_eq("t1_ret",  ret,  1);
    check_eq("t1_cyc4", cyc,  4);
    cycle(); check_eq("t1_cyc5", cyc, 5);
    check_eq("t1_done_drop", done, 0);

    // Load with three wait cycles in LD4
    do_reset();
    opcode = 6'b101000; mem_ready = 1'b1;
    repeat (3) cycle();
    check_eq("t2_ld4", state, 8);
    mem_ready = 1'b0;
    repeat (3) begin
      cycle();
      check_eq("t2_hold", state, 8);
      check_eq("t2_req",  mem_req, 1);
    end
    mem_ready = 1'b1;
    cycle(); check_eq("t2_ld5", state, 10);
    cycle(); check_eq("t2_if", state, 0);
    check_eq("t2_done", done, 1);

    // Store stalled two cycles in MEM3
    do_reset();
    opcode = 6'b101100; mem_ready = 1'b1;
    repeat (2) cycle();
    check_eq("t3_mem3", state, 7);
    stall = 1'b1;
    repeat (2) begin
      cycle();
      check_eq("t3_hold", state, 7);
      check_eq("t3_ret",  ret,   0);
    end
    stall = 1'b0;
    cycle(); check_eq("t3_st4", state, 9);
    cycle(); check_eq("t3_if", state, 0);
    check_eq("t3_ret1", ret, 1);
    check_eq("t3_cyc",  cyc, 6);

    // HALT is absorbing
    do_reset();
    opcode = 6'h3F;
    cycle(); check_eq("t4_rf", state, 1);
    cycle(); check_eq("t4_halt", state, 12);
    repeat (20) begin
      stall     = ($urandom_range(0, 3) == 0);
      mem_ready = $urandom_range(0, 1) == 1;
      cycle();
      check_eq("t4_halted", halted, 1);
      check_eq("t4_nodone", done, 0);
    end
    stall = 1'b0; mem_ready = 1'b1;
    do_reset();

    // Asynchronous reset while waiting in LD4
    opcode = 6'b101000;
    repeat (3) cycle();
    mem_ready = 1'b0;
    repeat (2) cycle();
    check_eq("t5_wait", state, 8);
    do_reset();
    mem_ready = 1'b1;

    // 16 jumps wrap the 4-bit retire counter
    opcode = 6'b110000;
    repeat (48) cycle();
    check_eq("t6_ret4", ret4, 0);
    check_eq("t6_ret",  ret,  16);
    check_eq("t6_done4", done4, 1);

    // Random traffic
    do_reset();
    repeat (3000) begin
      if (m_state == 0) begin
        opcode = 6'($urandom);
        if (opcode == 6'h3F && $urandom_range(0, 3) != 0) opcode = 6'h38;
      end
      stall     = ($urandom_range(0, 99) < 15);
      mem_ready = ($urandom_range(0, 99) < 60);
      cycle();
      if (m_state == 12 && $urandom_range(0, 9) == 0) do_reset();
      else if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
